mem_stage: RTL and testbench

//  Load/store stage directly downstream of exe_stage in the RV64 core. Accepts one

---
 rtl/mem_stage_pkg.sv | 33 +++
 rtl/mem_stage_align.sv | 46 ++++
 rtl/mem_stage.sv | 158 +++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the RV64 load/store stage.
// The misalignment helper is used only when MEM_MISALIGN_CHECK_EN is defined.
package mem_stage_pkg;

  localparam int XLEN       = 64;
  localparam int ADDR_ALIGN = 3;

  localparam logic [3:0] MEM_OP_NONE = 4'hF;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic bad;
    case (size)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = off[0];
      MEM_W:   bad = (off[1:0] != 2'd0);
      default: bad = (off != 3'd0);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: store shift and byte mask, load extract and extend.
// Accesses crossing the 8-byte beat keep only the lanes inside the beat.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            unsigned_ld,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] ld_beat,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      base_mask;

  always_comb begin
    shifted   = ld_beat >> {offset, 3'b000};
    wdata     = st_data << {offset, 3'b000};
    base_mask = 8'h00;
    ld_data   = {XLEN{1'b0}};
    case (size)
      MEM_B: begin
        base_mask = 8'h01;
        ld_data   = unsigned_ld ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        base_mask = 8'h03;
        ld_data   = unsigned_ld ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      MEM_W: begin
        base_mask = 8'h0F;
        ld_data   = unsigned_ld ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        // LD ignores the unsigned bit
        base_mask = 8'hFF;
        ld_data   = shifted;
      end
    endcase
    wmask = base_mask << offset;
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 load/store stage: ALU pass-through plus a REQ/WAIT handshake with the data RAM.
// Optional macro MEM_MISALIGN_CHECK_EN completes misaligned accesses without touching RAM.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [3:0]      mem_op,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] alu_data,
  input  logic            rd_w_ena_i,
  input  logic [4:0]      rd_w_addr_i,
  output logic            ram_req_valid,
  input  logic            ram_req_ready,
  output logic [XLEN-1:0] ram_req_addr,
  output logic            ram_req_wen,
  output logic [7:0]      ram_req_wmask,
  output logic [XLEN-1:0] ram_req_wdata,
  input  logic            ram_rsp_valid,
  input  logic [XLEN-1:0] ram_rsp_rdata,
  output logic            wb_valid,
  output logic            wb_w_ena,
  output logic [4:0]      wb_w_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign
);

  state_e          state_q, state_d;
  logic [3:0]      op_q;
  logic [2:0]      off_q;
  logic            rd_wr_q;
  logic [4:0]      rd_addr_q;

  logic            idle, accept, is_mem, mis, rd_wr;
  logic [1:0]      al_size;
  logic            al_uns;
  logic [2:0]      al_off;
  logic [7:0]      al_wmask;
  logic [XLEN-1:0] al_wdata, al_ld;

  assign idle   = (state_q == S_IDLE);
  assign accept = ex_valid & ex_ready;
  assign is_mem = (mem_op != MEM_OP_NONE);
  assign rd_wr  = rd_w_ena_i & (rd_w_addr_i != 5'd0);

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = is_mem & misaligned(mem_op[1:0], mem_addr[2:0]);
`else
  assign mis = 1'b0;
`endif

  // Store path uses the live inputs in IDLE; load extract uses the latched op in WAIT
  assign al_size = idle ? mem_op[1:0]   : op_q[1:0];
  assign al_uns  = idle ? mem_op[2]     : op_q[2];
  assign al_off  = idle ? mem_addr[2:0] : off_q;

  mem_align u_align (
    .size        (al_size),
    .unsigned_ld (al_uns),
    .offset      (al_off),
    .st_data     (mem_wdata),
    .ld_beat     (ram_rsp_rdata),
    .wmask       (al_wmask),
    .wdata       (al_wdata),
    .ld_data     (al_ld)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (accept && is_mem && !mis) ? S_REQ : S_IDLE;
      S_REQ:   state_d = ram_req_ready ? S_WAIT : S_REQ;
      S_WAIT:  state_d = ram_rsp_valid ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ex_ready      <= 1'b1;
      op_q          <= 4'd0;
      off_q         <= 3'd0;
      rd_wr_q       <= 1'b0;
      rd_addr_q     <= 5'd0;
      ram_req_valid <= 1'b0;
      ram_req_addr  <= {XLEN{1'b0}};
      ram_req_wen   <= 1'b0;
      ram_req_wmask <= 8'h00;
      ram_req_wdata <= {XLEN{1'b0}};
      wb_valid      <= 1'b0;
      wb_w_ena      <= 1'b0;
      wb_w_addr     <= 5'd0;
      wb_data       <= {XLEN{1'b0}};
      misalign      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ex_ready <= (state_d == S_IDLE);
      wb_valid <= 1'b0;
      wb_w_ena <= 1'b0;
      misalign <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && !is_mem) begin
            wb_valid  <= 1'b1;
            wb_w_ena  <= rd_wr;
            wb_w_addr <= rd_w_addr_i;
            wb_data   <= alu_data;
          end else if (accept && mis) begin
            wb_valid  <= 1'b1;
            wb_w_addr <= rd_w_addr_i;
            wb_data   <= {XLEN{1'b0}};
            misalign  <= 1'b1;
          end else if (accept) begin
            op_q          <= mem_op;
            off_q         <= mem_addr[2:0];
            rd_wr_q       <= rd_wr;
            rd_addr_q     <= rd_w_addr_i;
            ram_req_valid <= 1'b1;
            ram_req_addr  <= {mem_addr[XLEN-1:ADDR_ALIGN], {ADDR_ALIGN{1'b0}}};
            ram_req_wen   <= mem_op[3];
            ram_req_wmask <= mem_op[3] ? al_wmask : 8'h00;
            ram_req_wdata <= mem_op[3] ? al_wdata : {XLEN{1'b0}};
          end else begin
            ram_req_valid <= 1'b0;
          end
        end
        S_REQ: begin
          if (ram_req_ready) begin
            ram_req_valid <= 1'b0;
            ram_req_wen   <= 1'b0;
            ram_req_wmask <= 8'h00;
            ram_req_wdata <= {XLEN{1'b0}};
          end else begin
            ram_req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (ram_rsp_valid) begin
            wb_valid  <= 1'b1;
            wb_w_ena  <= rd_wr_q & ~op_q[3];
            wb_w_addr <= rd_addr_q;
            wb_data   <= op_q[3] ? {XLEN{1'b0}} : al_ld;
          end else begin
            wb_valid  <= 1'b0;
          end
        end
        default: begin
          ram_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage with a transaction-level model.
// Honours MEM_MISALIGN_CHECK_EN the same way the design does.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [3:0]  mem_op = 4'hF;
  logic [63:0] mem_addr = 64'd0, mem_wdata = 64'd0, alu_data = 64'd0;
  logic        rd_w_ena_i = 1'b0;
  logic [4:0]  rd_w_addr_i = 5'd0;
  logic        ram_req_valid, ram_req_wen;
  logic        ram_req_ready = 1'b0;
  logic [63:0] ram_req_addr, ram_req_wdata;
  logic [7:0]  ram_req_wmask;
  logic        ram_rsp_valid = 1'b0;
  logic [63:0] ram_rsp_rdata = 64'd0;
  logic        wb_valid, wb_w_ena, misalign;
  logic [4:0]  wb_w_addr;
  logic [63:0] wb_data;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .alu_data(alu_data),
    .rd_w_ena_i(rd_w_ena_i), .rd_w_addr_i(rd_w_addr_i),
    .ram_req_valid(ram_req_valid), .ram_req_ready(ram_req_ready), .ram_req_addr(ram_req_addr),
    .ram_req_wen(ram_req_wen), .ram_req_wmask(ram_req_wmask), .ram_req_wdata(ram_req_wdata),
    .ram_rsp_valid(ram_rsp_valid), .ram_rsp_rdata(ram_rsp_rdata),
    .wb_valid(wb_valid), .wb_w_ena(wb_w_ena), .wb_w_addr(wb_w_addr), .wb_data(wb_data),
    .misalign(misalign)
  );

  typedef struct {
    int          due;
    logic        ena;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        chk_data;
    logic        mis;
  } wb_t;

  wb_t         exp_q[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic        busy = 1'b0, req_exp = 1'b0;
  logic [63:0] e_addr = 64'd0, e_wdata = 64'd0;
  logic        e_wen = 1'b0;
  logic [7:0]  e_mask = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: bytes of the beat starting at the offset, only lanes that lie in the beat
  function automatic logic [63:0] m_load(input logic [3:0] op, input logic [63:0] addr,
                                         input logic [63:0] beat);
    int nb = 1 << op[1:0];
    int off = int'(addr[2:0]);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < nb; i++)
      if (off + i < 8) v[8*i +: 8] = beat[8*(off+i) +: 8];
    if (!op[2] && nb < 8 && v[8*nb-1])
      for (int b = 8*nb; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] m_mask(input logic [3:0] op, input logic [63:0] addr);
    int nb = 1 << op[1:0];
    int off = int'(addr[2:0]);
    logic [7:0] m = 8'h00;
    for (int i = 0; i < nb; i++)
      if (off + i < 8) m[off+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] addr, input logic [63:0] wd);
    int off = int'(addr[2:0]);
    logic [63:0] w = 64'd0;
    for (int i = 0; i < 8; i++)
      if (off + i < 8) w[8*(off+i) +: 8] = wd[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] bytes_in(input logic [63:0] x, input logic [7:0] m);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < 8; i++)
      if (m[i]) r[8*i +: 8] = x[8*i +: 8];
    return r;
  endfunction

  function automatic logic m_mis(input logic [3:0] op, input logic [63:0] addr);
    int nb = 1 << op[1:0];
    return (int'(addr[2:0]) % nb) != 0;
  endfunction

  // Per-cycle comparison of DUT outputs against the model state
  always @(negedge clk) begin
    if (!rst) begin
      wb_t w;
      check("ex_ready", ex_ready, !busy);
      check("req_valid", ram_req_valid, req_exp);
      if (req_exp && ram_req_valid) begin
        check("req_addr", ram_req_addr, e_addr);
        check("req_wen", ram_req_wen, e_wen);
        if (e_wen) begin
          check("req_wmask", ram_req_wmask, e_mask);
          check("req_wdata", bytes_in(ram_req_wdata, e_mask), bytes_in(e_wdata, e_mask));
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        w = exp_q.pop_front();
        check("wb_valid", wb_valid, 1'b1);
        check("wb_w_ena", wb_w_ena, w.ena);
        check("wb_w_addr", wb_w_addr, w.addr);
        check("misalign", misalign, w.mis);
        if (w.chk_data) check("wb_data", wb_data, w.data);
      end else begin
        check("wb_idle", wb_valid, 1'b0);
        check("misalign_idle", misalign, 1'b0);
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] alu, input logic rena, input logic [4:0] rd,
                       input logic [63:0] beat, input int wr, input int wrsp, input bit stale);
    int   n = 0;
    logic mis = 1'b0;
    wb_t  w;
    while (!ex_ready && n < 20) begin tick(); n++; end
    if (n >= 20) check("ex_ready_timeout", ex_ready, 1'b1);
    ex_valid = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wd;
    alu_data = alu; rd_w_ena_i = rena; rd_w_addr_i = rd;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = (op != 4'hF) && m_mis(op, addr);
`endif
    if (op == 4'hF || mis) begin
      w = '{cyc + 1, (op == 4'hF) && rena && rd != 5'd0, rd, alu, op == 4'hF, mis};
      exp_q.push_back(w);
      tick();
      ex_valid = 1'b0;
      return;
    end
    e_addr  = {addr[63:3], 3'b000};
    e_wen   = op[3];
    e_mask  = m_mask(op, addr);
    e_wdata = m_wdata(addr, wd);
    tick();
    busy = 1'b1; req_exp = 1'b1;
    // Upstream presents unrelated traffic while the stage is busy
    ex_valid = 1'($urandom_range(0, 1)); mem_op = 4'($urandom);
    mem_addr = {$urandom, $urandom}; alu_data = {$urandom, $urandom}; rd_w_addr_i = 5'($urandom);
    for (int i = 0; i < wr; i++) begin
      ram_rsp_valid = stale ? 1'($urandom_range(0, 1)) : 1'b0;
      ram_rsp_rdata = {$urandom, $urandom};
      tick();
    end
    ram_rsp_valid = 1'b0; ram_req_ready = 1'b1;
    tick();
    req_exp = 1'b0; ram_req_ready = 1'b0;
    for (int i = 0; i < wrsp; i++) tick();
    ram_rsp_valid = 1'b1; ram_rsp_rdata = beat; ex_valid = 1'b0;
    w = '{cyc + 1, !op[3] && rena && rd != 5'd0, rd, m_load(op, addr, beat), !op[3], 1'b0};
    exp_q.push_back(w);
    tick();
    busy = 1'b0; ram_rsp_valid = 1'b0; ram_rsp_rdata = {$urandom, $urandom};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    repeat (2) tick();
    check("rst_ex_ready", ex_ready, 1'b1);
    check("rst_req_valid", ram_req_valid, 1'b0);
    check("rst_req_wmask", ram_req_wmask, 8'h00);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_misalign", misalign, 1'b0);
    rst = 1'b0;
    tick();

    check("pin_lb", m_load(4'b0000, 64'h8000_0003, 64'h0000_0000_8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
    check("pin_lbu", m_load(4'b0100, 64'h8000_0003, 64'h0000_0000_8000_0000), 64'h80);
    check("pin_sh_mask", m_mask(4'b1001, 64'h8000_0006), 8'hC0);
    check("pin_sh_data", m_wdata(64'h8000_0006, 64'hABCD) & 64'hFFFF_0000_0000_0000, 64'hABCD_0000_0000_0000);

    do_op(4'hF, 64'd0, 64'd0, 64'h1234, 1'b1, 5'd5, 64'd0, 0, 0, 0);
    check("alu_data_lit", wb_data, 64'h1234);
    check("alu_ena_lit", wb_w_ena, 1'b1);
    do_op(4'b0000, 64'h8000_0003, 64'd0, 64'd0, 1'b1, 5'd7, 64'h0000_0000_8000_0000, 0, 0, 0);
    check("lb_lit", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    do_op(4'b0100, 64'h8000_0003, 64'd0, 64'd0, 1'b1, 5'd7, 64'h0000_0000_8000_0000, 0, 0, 0);
    check("lbu_lit", wb_data, 64'h80);
    do_op(4'b1001, 64'h8000_0006, 64'hABCD, 64'd0, 1'b1, 5'd3, 64'd0, 5, 1, 1);
    check("sh_ena_lit", wb_w_ena, 1'b0);
    do_op(4'b0011, 64'h8000_0010, 64'd0, 64'd0, 1'b1, 5'd0, 64'h1122_3344_5566_7788, 0, 2, 0);
    check("x0_data_lit", wb_data, 64'h1122_3344_5566_7788);
    check("x0_ena_lit", wb_w_ena, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
    do_op(4'b0010, 64'h8000_0002, 64'd0, 64'd0, 1'b1, 5'd9, 64'd0, 0, 0, 0);
    check("mis_lit", misalign, 1'b1);
`endif

    // Reset while waiting for the response; the late response must be dropped
    ex_valid = 1'b1; mem_op = 4'b0011; mem_addr = 64'h8000_0020; rd_w_ena_i = 1'b1; rd_w_addr_i = 5'd4;
    e_addr = 64'h8000_0020; e_wen = 1'b0;
    tick();
    busy = 1'b1; req_exp = 1'b1; ex_valid = 1'b0; ram_req_ready = 1'b1;
    tick();
    req_exp = 1'b0; ram_req_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; busy = 1'b0;
    check("rstw_ex_ready", ex_ready, 1'b1);
    check("rstw_req_valid", ram_req_valid, 1'b0);
    ram_rsp_valid = 1'b1;
    tick();
    ram_rsp_valid = 1'b0;
    repeat (2) tick();
    do_op(4'hF, 64'd0, 64'd0, 64'hCAFE_F00D, 1'b1, 5'd12, 64'd0, 0, 0, 0);
    check("post_rst_alu", wb_data, 64'hCAFE_F00D);

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 3) == 0) op = 4'hF;
      else if ($urandom_range(0, 1) == 1) op = {2'b10, 2'($urandom)};
      else op = {1'b0, 1'($urandom), 2'($urandom)};
      do_op(op, 64'h8000_0000 + 64'($urandom_range(0, 4095)), {$urandom, $urandom},
            {$urandom, $urandom}, ($urandom_range(0, 7) != 0), 5'($urandom),
            {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 2),
            ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 3) == 0) tick();
    end
    repeat (3) tick();
    check("exp_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
